// File: rtl/lc3b_mem_responder_if.sv
// LC-3b memory bus between the CPU (master) and a memory responder (slave).
// Requests are level-held by the master until the slave pulses mem_resp.
interface lc3b_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    modport master (
        output mem_read,
        output mem_write,
        output mem_byte_enable,
        output mem_address,
        output mem_wdata,
        input  mem_resp,
        input  mem_rdata
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_byte_enable,
        input  mem_address,
        input  mem_wdata,
        output mem_resp,
        output mem_rdata
    );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Word-organised LC-3b memory model with a fixed request-to-response latency
// and a backdoor preload port that is honoured only while idle.
module lc3b_mem_responder #(
    parameter int DELAY     = 3,
    parameter int ADDR_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    lc3b_mem_responder_if.slave        bus,
    input  logic                       init_we,
    input  logic [ADDR_BITS-1:0]       init_addr,
    input  logic [15:0]                init_data,
    output logic                       proto_err
);
    localparam int WORDS = 2 ** ADDR_BITS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(DELAY - 1);

    logic [1:0]           state;
    logic [3:0]           cnt;
    logic                 resp;
    logic [15:0]          rdata;
    logic [15:0]          mem [WORDS];

    logic                 op_write;
    logic [ADDR_BITS-1:0] idx;
    logic [1:0]           be;
    logic [15:0]          wdata;

    logic                 accept;
    logic                 unused_addr_bits;

    assign accept = (state == IDLE) && (bus.mem_read || bus.mem_write);

    // Byte-address bit 0 and bits above the word index alias silently.
    assign unused_addr_bits = ^{bus.mem_address[15:ADDR_BITS+1], bus.mem_address[0]};

    assign bus.mem_resp  = resp;
    assign bus.mem_rdata = rdata;

    // Request capture: these only matter after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_write <= bus.mem_write & ~bus.mem_read;
            idx      <= bus.mem_address[ADDR_BITS:1];
            be       <= bus.mem_byte_enable;
            wdata    <= bus.mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            resp      <= 1'b0;
            rdata     <= '0;
            proto_err <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_we) begin
                        mem[init_addr] <= init_data;
                    end
                    if (accept) begin
                        if (bus.mem_read && bus.mem_write) begin
                            proto_err <= 1'b1;
                        end
                        cnt   <= CNT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        // Memory is touched on RESP entry so a same-edge preload is visible.
                        state <= RESP;
                        resp  <= 1'b1;
                        if (op_write) begin
                            if (be[0]) mem[idx][7:0]  <= wdata[7:0];
                            if (be[1]) mem[idx][15:8] <= wdata[15:8];
                        end else begin
                            rdata <= mem[idx];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench for lc3b_mem_responder: requests push expected responses into a
// scoreboard that an independent negedge monitor pops and compares.
module tb_lc3b_mem_responder;
    localparam int DLY = 3;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t sb[$];
    exp_t e;
    logic prev_resp = 1'b0;

    lc3b_mem_responder_if bus ();
    lc3b_mem_responder_if bus1 ();

    logic        init_we = 1'b0;
    logic [7:0]  init_addr = '0;
    logic [15:0] init_data = '0;
    logic        proto_err;

    logic        init1_we = 1'b0;
    logic [7:0]  init1_addr = '0;
    logic [15:0] init1_data = '0;
    logic        proto_err1;

    lc3b_mem_responder #(.DELAY(DLY), .ADDR_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .proto_err (proto_err)
    );

    lc3b_mem_responder #(.DELAY(1), .ADDR_BITS(8)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus1),
        .init_we   (init1_we),
        .init_addr (init1_addr),
        .init_data (init1_data),
        .proto_err (proto_err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.mem_resp) begin
            if (prev_resp) begin
                tests++;
                fails++;
                $display("FAIL resp_consecutive: mem_resp high two cycles in a row at cycle %0d", cyc);
            end
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL resp_unexpected: mem_resp with rdata %0h at cycle %0d, none expected", bus.mem_rdata, cyc);
            end else begin
                e = sb.pop_front();
                check("resp_rdata", int'(bus.mem_rdata), int'(e.data));
                check("resp_cycle", cyc, e.cyc);
            end
        end
        prev_resp = bus.mem_resp;
    end

    task automatic start_req(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [1:0] be, input logic [15:0] wd, input logic [15:0] exp_rd);
        @(negedge clk);
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_address     = addr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        sb.push_back('{cyc + 1 + DLY, exp_rd});
    endtask

    task automatic finish_req(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_resp;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no mem_resp within 40 cycles, got 0 expected 1", name);
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [1:0] be, input logic [15:0] wd, input logic [15:0] exp_rd,
                          input string name);
        start_req(rd, wr, addr, be, wd, exp_rd);
        finish_req(name);
    endtask

    initial begin
        int acc;
        int n;
        int seen_cyc;
        logic [15:0] seen_data;

        bus.mem_read = 1'b0;  bus.mem_write = 1'b0;
        bus.mem_address = '0; bus.mem_byte_enable = '0; bus.mem_wdata = '0;
        bus1.mem_read = 1'b0; bus1.mem_write = 1'b0;
        bus1.mem_address = '0; bus1.mem_byte_enable = '0; bus1.mem_wdata = '0;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_resp", int'(bus.mem_resp), 0);
        check("reset_rdata", int'(bus.mem_rdata), 0);
        check("reset_proto_err", int'(proto_err), 0);

        // Preload then read word 5
        @(negedge clk);
        init_we = 1'b1; init_addr = 8'h05; init_data = 16'hBEEF;
        @(negedge clk);
        init_we = 1'b0;
        access(1, 0, 16'h000A, 2'b00, 16'h0000, 16'hBEEF, "preload_read");

        // Preload and accept on the same edge
        @(negedge clk);
        init_we = 1'b1; init_addr = 8'h06; init_data = 16'h1111;
        bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.mem_address = 16'h000C;
        sb.push_back('{cyc + 1 + DLY, 16'h1111});
        @(negedge clk);
        init_we = 1'b0;
        finish_req("same_edge_preload");

        // Byte-enable writes; a write leaves rdata at the last read value
        access(0, 1, 16'h0010, 2'b01, 16'h1234, 16'h1111, "wr_be01");
        access(1, 0, 16'h0010, 2'b00, 16'h0000, 16'h0034, "rd_be01");
        access(0, 1, 16'h0010, 2'b10, 16'hABCD, 16'h0034, "wr_be10");
        access(1, 0, 16'h0010, 2'b00, 16'h0000, 16'hAB34, "rd_be10");
        access(0, 1, 16'h0010, 2'b00, 16'hFFFF, 16'hAB34, "wr_be00");
        access(1, 0, 16'h0010, 2'b00, 16'h0000, 16'hAB34, "rd_be00");

        // Backdoor write during WAIT must be ignored
        start_req(1, 0, 16'h0014, 2'b00, 16'h0000, 16'h0000);
        @(negedge clk);
        init_we = 1'b1; init_addr = 8'h0A; init_data = 16'h9999;
        @(negedge clk);
        init_we = 1'b0;
        finish_req("init_in_wait");
        access(1, 0, 16'h0014, 2'b00, 16'h0000, 16'h0000, "init_in_wait_reread");

        // mem_read held continuously: accepts every DLY+2 cycles
        @(negedge clk);
        bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.mem_address = 16'h000A;
        acc = cyc + 1;
        for (int k = 0; k < 3; k++) sb.push_back('{acc + DLY + (DLY + 2) * k, 16'hBEEF});
        n = 0;
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(negedge clk);
            if (bus.mem_resp) n++;
        end
        bus.mem_read = 1'b0;
        check("b2b_resp_count", n, 3);

        // Read and write together: read semantics, sticky proto_err
        check("proto_err_before", int'(proto_err), 0);
        access(1, 1, 16'h0004, 2'b11, 16'hFFFF, 16'h0000, "rw_both");
        check("proto_err_set", int'(proto_err), 1);
        access(1, 0, 16'h0004, 2'b00, 16'h0000, 16'h0000, "rw_mem_unchanged");
        access(1, 0, 16'h000A, 2'b00, 16'h0000, 16'hBEEF, "clean_after_rw");
        check("proto_err_sticky", int'(proto_err), 1);

        // Reset in the middle of a write's WAIT
        @(negedge clk);
        bus.mem_write = 1'b1; bus.mem_read = 1'b0;
        bus.mem_address = 16'h0002; bus.mem_byte_enable = 2'b11; bus.mem_wdata = 16'h5555;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.mem_write = 1'b0;
        check("midreset_proto_err", int'(proto_err), 0);
        check("midreset_rdata", int'(bus.mem_rdata), 0);
        check("midreset_resp", int'(bus.mem_resp), 0);
        repeat (6) @(negedge clk);
        access(1, 0, 16'h0002, 2'b00, 16'h0000, 16'h0000, "midreset_reread");
        access(1, 0, 16'h000A, 2'b00, 16'h0000, 16'h0000, "midreset_preload_cleared");

        // Aliasing: address bits above ADDR_BITS are ignored
        access(0, 1, 16'h0202, 2'b11, 16'h7777, 16'h0000, "alias_wr");
        access(1, 0, 16'h0002, 2'b00, 16'h0000, 16'h7777, "alias_rd");

        // DELAY=1 instance
        @(negedge clk);
        init1_we = 1'b1; init1_addr = 8'h03; init1_data = 16'h4321;
        @(negedge clk);
        init1_we = 1'b0;
        bus1.mem_read = 1'b1; bus1.mem_address = 16'h0006;
        acc = cyc + 1;
        seen_cyc = -1;
        seen_data = '0;
        for (int i = 0; i < 10 && seen_cyc < 0; i++) begin
            @(negedge clk);
            if (bus1.mem_resp) begin
                seen_cyc = cyc;
                seen_data = bus1.mem_rdata;
                bus1.mem_read = 1'b0;
            end
        end
        bus1.mem_read = 1'b0;
        check("d1_resp_cycle", seen_cyc, acc + 1);
        check("d1_rdata", int'(seen_data), 16'h4321);
        @(negedge clk);
        check("d1_resp_single", int'(bus1.mem_resp), 0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
